// File: rtl/runway_pkg.sv
// Shared definitions for the runway sequencer and the pattern generator it
// feeds: sequencer state encoding, generator mode codes, and the mapping
// from the raw wind switches to a generator mode.
package runway_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LAND  = 2'd1,
        CLEAR = 2'd2
    } rs_state_t;

    localparam logic [1:0] MODE_CALM = 2'b00;
    localparam logic [1:0] MODE_R2L  = 2'b01;
    localparam logic [1:0] MODE_L2R  = 2'b10;

    // Wind code 11 has no pattern of its own, so it falls back to CALM.
    function automatic logic [1:0] wind_to_mode(input logic [1:0] wind);
        return (wind == 2'b11) ? MODE_CALM : wind;
    endfunction

endpackage

// File: rtl/runway_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports:
//   i_req      N_REQ  request vector
//   i_ptr      PTR_W  index with highest priority this round
//   o_valid    1      any request present
//   o_winner   PTR_W  index of the first set request at or after i_ptr
//   o_onehot   N_REQ  one-hot form of o_winner (zero when !o_valid)
module rr_arbiter #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [PTR_W-1:0] o_winner,
    output logic [N_REQ-1:0] o_onehot
);

    // w_cand[k] is the index visited k-th in the scan starting at i_ptr.
    logic [PTR_W-1:0] w_cand [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            assign w_cand[gi] = PTR_W'((32'(i_ptr) + gi) % N_REQ);
        end
    endgenerate

    // Scan from the far end back toward i_ptr so the nearest hit wins.
    always_comb begin
        o_valid  = 1'b0;
        o_winner = '0;
        o_onehot = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_valid  = 1'b1;
                o_winner = w_cand[k];
            end
        end
        if (o_valid) begin
            o_onehot[o_winner] = 1'b1;
        end
    end

endmodule

// File: rtl/runway_sequencer.sv
// runway_sequencer: grants the single runway pattern generator to one of
// N_REQ requesters at a time, round-robin, advancing only on i_tick.
// Ports:
//   i_clk        system clock
//   i_reset      asynchronous active-high reset
//   i_tick       one-cycle enable; all registers hold when low
//   i_req        level landing requests
//   i_wind       wind switches, latched at grant
//   o_grant      one-hot grant (registered)
//   o_busy       high in LAND or CLEAR
//   o_mode       generator mode (CALM outside LAND)
//   o_active_id  granted requester index, 0 when none
module runway_sequencer
    import runway_pkg::*;
#(
    parameter int N_REQ      = 3,
    parameter int LAND_TICKS = 6,
    parameter int GAP_TICKS  = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tick,
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_wind,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_busy,
    output logic [1:0]       o_mode,
    output logic [1:0]       o_active_id
);

    localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (LAND_TICKS > GAP_TICKS) ? LAND_TICKS : GAP_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    rs_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [N_REQ-1:0] r_grant;
    logic             r_busy;
    logic [1:0]       r_mode;
    logic [1:0]       r_active_id;

    logic             w_valid;
    logic [PTR_W-1:0] w_winner;
    logic [N_REQ-1:0] w_onehot;
    logic             w_land_done;
    logic             w_abort;
    logic [PTR_W-1:0] w_next_ptr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req    (i_req),
        .i_ptr    (r_rr_ptr),
        .o_valid  (w_valid),
        .o_winner (w_winner),
        .o_onehot (w_onehot)
    );

    assign w_land_done = (r_cnt == CNT_W'(LAND_TICKS - 1));
    // Requester withdrew mid-landing: leave the runway early.
    assign w_abort     = ~i_req[r_active_id[PTR_W-1:0]];
    // The requester just served drops to lowest priority for the next round.
    assign w_next_ptr  = (r_active_id == 2'(N_REQ - 1)) ? '0
                                                          : PTR_W'(r_active_id + 2'd1);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_mode      <= MODE_CALM;
            r_active_id <= 2'd0;
        end else if (i_tick) begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state     <= LAND;
                        r_grant     <= w_onehot;
                        r_active_id <= 2'(w_winner);
                        r_mode      <= wind_to_mode(i_wind);
                        r_busy      <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                LAND: begin
                    if (w_land_done || w_abort) begin
                        r_state     <= CLEAR;
                        r_grant     <= '0;
                        r_mode      <= MODE_CALM;
                        r_cnt       <= '0;
                        r_rr_ptr    <= w_next_ptr;
                        r_active_id <= 2'd0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    if (r_cnt == CNT_W'(GAP_TICKS - 1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_busy  <= 1'b0;
                    r_mode  <= MODE_CALM;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_grant     = r_grant;
    assign o_busy      = r_busy;
    assign o_mode      = r_mode;
    assign o_active_id = r_active_id;

endmodule

// File: tb/tb_runway_sequencer.sv
// Bench for runway_sequencer (N_REQ=3, LAND_TICKS=6, GAP_TICKS=2, tick
// every 4 clocks). Each new grant seen on the outputs is matched against a
// queue of expected landings filled by the stimulus process.
module tb_runway_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 1'b0;
    logic [2:0] req;
    logic [1:0] wind;
    logic [2:0] grant;
    logic       busy;
    logic [1:0] mode;
    logic [1:0] active_id;

    typedef struct {
        logic [2:0] grant;
        logic [1:0] mode;
        logic [1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    runway_sequencer #(
        .N_REQ      (3),
        .LAND_TICKS (6),
        .GAP_TICKS  (2)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_tick      (tick),
        .i_req       (req),
        .i_wind      (wind),
        .o_grant     (grant),
        .o_busy      (busy),
        .o_mode      (mode),
        .o_active_id (active_id)
    );

    always #5 clk = ~clk;

    // One-cycle tick every 4 clocks, changed on the falling edge.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d at %0t", name, act, $time);
        end
    endtask

    // Advance n tick edges, then settle 1 time unit past the edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (tick !== 1'b1);
        end
        #1;
    endtask

    task automatic push(input logic [2:0] g, input logic [1:0] m, input logic [1:0] id);
        exp_t e;
        e.grant = g;
        e.mode  = m;
        e.id    = id;
        exp_q.push_back(e);
    endtask

    // Monitor: every new non-zero grant is one landing transaction.
    logic [2:0] prev_grant = 3'b000;
    always @(negedge clk) begin
        if (rst === 1'b0 && grant !== prev_grant && grant !== 3'b000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got %b expected none", grant);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_grant", int'(grant), int'(e.grant));
                chk("mon_mode", int'(mode), int'(e.mode));
                chk("mon_id", int'(active_id), int'(e.id));
            end
        end
        if (rst === 1'b0 && mode !== 2'b00 && grant === 3'b000) begin
            n_checks++;
            n_fail++;
            $display("FAIL inv_mode_without_grant: got mode %b expected 00", mode);
        end
        if (rst === 1'b0 && !$onehot0(grant)) begin
            n_checks++;
            n_fail++;
            $display("FAIL inv_onehot: got grant %b expected one-hot or zero", grant);
        end
        prev_grant = grant;
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        req  = 3'b000;
        wind = 2'b00;

        // 1: reset state, then idle with no requests
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(grant), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_id", int'(active_id), 0);
        rst = 1'b0;
        wait_ticks(5);
        chk("idle_grant", int'(grant), 0);
        chk("idle_busy", int'(busy), 0);

        // 2: single landing, wind latched at grant
        req  = 3'b001;
        wind = 2'b01;
        push(3'b001, 2'b01, 2'd0);
        wait_ticks(1);
        chk("t2_grant", int'(grant), 1);
        chk("t2_busy", int'(busy), 1);
        wind = 2'b10;
        wait_ticks(5);
        chk("t2_hold_grant", int'(grant), 1);
        chk("t2_hold_mode", int'(mode), 1);
        wait_ticks(1);
        chk("t2_end_grant", int'(grant), 0);
        chk("t2_end_mode", int'(mode), 0);
        chk("t2_clear_busy", int'(busy), 1);
        req = 3'b000;
        wait_ticks(1);
        chk("t2_gap_busy", int'(busy), 1);
        wait_ticks(1);
        chk("t2_idle_busy", int'(busy), 0);

        // 3: all requesting, round-robin from pointer 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        req  = 3'b111;
        wind = 2'b01;
        push(3'b001, 2'b01, 2'd0);
        push(3'b010, 2'b01, 2'd1);
        push(3'b100, 2'b01, 2'd2);
        push(3'b001, 2'b01, 2'd0);
        for (int r = 0; r < 4; r++) begin
            wait_ticks(1);
            chk("t3_grant_up", int'(grant != 3'b000), 1);
            if (r < 3) begin
                wait_ticks(6);
                chk("t3_gap_grant", int'(grant), 0);
                chk("t3_gap_busy", int'(busy), 1);
                wait_ticks(2);
            end
        end
        req = 3'b000;
        wait_ticks(1);
        chk("t3_abort_grant", int'(grant), 0);
        wait_ticks(2);
        chk("t3_idle_busy", int'(busy), 0);

        // 4: wind=11 maps to CALM; pointer is now 1
        req  = 3'b010;
        wind = 2'b11;
        push(3'b010, 2'b00, 2'd1);
        wait_ticks(1);
        chk("t4_grant", int'(grant), 2);
        chk("t4_mode", int'(mode), 0);
        req = 3'b000;
        wait_ticks(3);
        chk("t4_idle_busy", int'(busy), 0);

        // 5: abort after 2 landing ticks moves pointer past requester 0
        req  = 3'b001;
        wind = 2'b10;
        push(3'b001, 2'b10, 2'd0);
        wait_ticks(1);
        wait_ticks(2);
        chk("t5_still_grant", int'(grant), 1);
        req = 3'b000;
        wait_ticks(1);
        chk("t5_abort_grant", int'(grant), 0);
        chk("t5_abort_busy", int'(busy), 1);
        wait_ticks(2);
        chk("t5_idle_busy", int'(busy), 0);
        req = 3'b011;
        push(3'b010, 2'b10, 2'd1);
        wait_ticks(1);
        chk("t5_next_grant", int'(grant), 2);

        // 6: async reset mid-landing
        wait_ticks(1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_grant", int'(grant), 0);
        chk("t6_rst_mode", int'(mode), 0);
        chk("t6_rst_busy", int'(busy), 0);
        req = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        wait_ticks(3);
        chk("t6_idle_grant", int'(grant), 0);
        chk("t6_idle_busy", int'(busy), 0);
        req = 3'b010;
        push(3'b010, 2'b10, 2'd1);
        wait_ticks(1);
        chk("t6_regrant", int'(grant), 2);
        req = 3'b000;
        wait_ticks(3);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
